code_tx: RTL and testbench

- Serial transmitter for the microcontroller-to-FPGA code link. It is the sending end of the existing 48-bit code receiver.
- It takes 32-bit code words through a valid/ready handshake and adds the per-byte offset. It then serialises continuous fixed-period frames on a one-wire data line, sharing the receiver's clock.
- Used as the link model in simulation, and as the FPGA-to-FPGA loopback transmitter for bring-up.

---
 rtl/code_link_pkg.sv | 50 +++++
 rtl/code_frame_enc.sv | 21 ++
 rtl/code_tx.sv | 88 ++++++++
 tb/tb_code_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/code_link_pkg.sv
// ============================================================================
//  Module      : code_link_pkg
//  Description : Shared constants and the byte map (encode/decode) for the
//                48-bit microcontroller-to-FPGA code link.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package code_link_pkg;

    localparam int FRAME_BITS = 48;
    localparam int GAP_SLOTS  = 1;
    localparam int SLOT_MAX   = FRAME_BITS + GAP_SLOTS - 1;
    localparam int SLOT_W     = $clog2(SLOT_MAX + 1);

    localparam logic [7:0] BYTE_OFFSET = 8'd30;
    localparam logic [7:0] MARK0       = 8'hA5;
    localparam logic [7:0] MARK3       = 8'h5A;

    typedef logic [SLOT_W-1:0]     slot_t;
    typedef logic [FRAME_BITS-1:0] frame_t;

    // Payload bytes are scrambled across the frame; byte 0 goes out first.
    function automatic frame_t encode_frame(input logic [31:0] w);
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b4;
        logic [7:0] b5;
        b1 = w[23:16] + BYTE_OFFSET;
        b2 = w[31:24] + BYTE_OFFSET;
        b4 = w[7:0]   + BYTE_OFFSET;
        b5 = w[15:8]  + BYTE_OFFSET;
        return {b5, b4, MARK3, b2, b1, MARK0};
    endfunction

    function automatic logic [31:0] decode_frame(input frame_t f);
        logic [7:0] w3;
        logic [7:0] w2;
        logic [7:0] w1;
        logic [7:0] w0;
        w3 = f[23:16] - BYTE_OFFSET;
        w2 = f[15:8]  - BYTE_OFFSET;
        w1 = f[47:40] - BYTE_OFFSET;
        w0 = f[39:32] - BYTE_OFFSET;
        return {w3, w2, w1, w0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/code_frame_enc.sv
// ============================================================================
//  Module      : code_frame_enc
//  Description : Combinational 32-bit payload to 48-bit link frame encoder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module code_frame_enc
    import code_link_pkg::*;
(
    input  logic [31:0] word,
    output frame_t      frame
);

    always_comb begin
        frame = encode_frame(word);
    end

endmodule

`default_nettype wire

// File: rtl/code_tx.sv
// ============================================================================
//  Module      : code_tx
//  Description : Continuous fixed-period serial transmitter for the code link,
//                with a one-entry input buffer and last-word repeat.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module code_tx
    import code_link_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] code_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        code,
    output logic        frame_start,
    output logic        frame_done
);

    localparam slot_t  c_SLOT_MAX   = slot_t'(SLOT_MAX);
    localparam slot_t  c_DATA_SLOTS = slot_t'(FRAME_BITS);
    localparam frame_t c_IDLE_FRAME = encode_frame(32'd0);

    slot_t       r_slot;
    logic [31:0] r_hold;
    logic        r_hold_valid;
    logic [31:0] r_last;
    frame_t      r_sreg;
    logic        r_code;
    logic        r_frame_start;
    logic        r_frame_done;

    logic [31:0] w_next_word;
    frame_t      w_next_frame;

    assign w_next_word = r_hold_valid ? r_hold : r_last;

    code_frame_enc u_enc (
        .word  (w_next_word),
        .frame (w_next_frame)
    );

    // r_slot leads the line by one clock: the output register shows the bit
    // selected by the previous slot value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot        <= '0;
            r_hold        <= '0;
            r_hold_valid  <= 1'b0;
            r_last        <= '0;
            r_sreg        <= c_IDLE_FRAME;
            r_code        <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_start <= (r_slot == '0);
            r_frame_done  <= (r_slot == c_SLOT_MAX);
            r_code        <= (r_slot < c_DATA_SLOTS) ? r_sreg[r_slot] : 1'b0;

            if (r_slot == c_SLOT_MAX) begin
                r_slot <= '0;
                r_sreg <= w_next_frame;
                if (r_hold_valid) begin
                    r_last       <= r_hold;
                    r_hold_valid <= 1'b0;
                end
            end else begin
                r_slot <= r_slot + slot_t'(1);
            end

            // Never collides with the reload clear: acceptance needs hold empty.
            if (in_valid && !r_hold_valid) begin
                r_hold       <= code_in;
                r_hold_valid <= 1'b1;
            end
        end
    end

    assign in_ready    = !r_hold_valid;
    assign code        = r_code;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_code_tx.sv
// ============================================================================
//  Module      : tb_code_tx
//  Description : Directed self-checking bench for code_tx.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_code_tx;

    localparam logic [47:0] F_IDLE = 48'h1E1E5A1E1EA5;
    localparam logic [47:0] F_1234 = 48'h74965A3052A5;
    localparam logic [47:0] F_FFFF = 48'h1D1D5A1D1DA5;
    localparam logic [47:0] F_AAAA = 48'h1E1F5AC8C8A5;
    localparam logic [47:0] F_BBBB = 48'hD9D95A1E1EA5;
    localparam logic [47:0] F_CAFE = 48'h1F205AE81CA5;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] code_in;
    logic        in_valid;
    logic        in_ready;
    logic        code;
    logic        frame_start;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    code_tx dut (
        .clk         (clk),
        .rst         (rst),
        .code_in     (code_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .code        (code),
        .frame_start (frame_start),
        .frame_done  (frame_done)
    );

    // Receiver byte map written out independently of the RTL package.
    function automatic logic [31:0] rx_decode(input logic [47:0] f);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] d;
        a = f[23:16] - 8'd30;
        b = f[15:8]  - 8'd30;
        c = f[47:40] - 8'd30;
        d = f[39:32] - 8'd30;
        return {a, b, c, d};
    endfunction

    task automatic sync_frame(output bit ok);
        int n;
        n = 0;
        while (frame_start !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (frame_start === 1'b1);
    endtask

    // Starts at the negedge of slot 0, ends at the negedge of the gap slot.
    task automatic grab_frame(output logic [47:0] f, output logic gap, output int marks);
        marks = 0;
        gap   = 1'bx;
        for (int i = 0; i < 49; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 48) f[i] = code;
            else        gap  = code;
            if (frame_start !== (i == 0))  marks++;
            if (frame_done  !== (i == 48)) marks++;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        code_in  = w;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        in_valid = 1'b0;
        code_in  = '0;
        repeat (3) @(negedge clk);
        n_vec++; if (code !== 1'b0) begin n_err++; $display("FAIL reset_code: got %b expected 0", code); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_vec++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
        n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL cycle0_frame_start: got %b expected 1", frame_start); end
        n_vec++; if (code !== 1'b1) begin n_err++; $display("FAIL cycle0_code: got %b expected 1", code); end
    endtask

    task automatic test_idle;
        logic [47:0] f;
        logic        gap;
        int          marks;
        bit          ok;
        grab_frame(f, gap, marks);
        n_vec++; if (f !== F_IDLE) begin n_err++; $display("FAIL idle_frame: got %h expected %h", f, F_IDLE); end
        n_vec++; if (gap !== 1'b0) begin n_err++; $display("FAIL idle_gap: got %b expected 0", gap); end
        n_vec++; if (marks !== 0) begin n_err++; $display("FAIL idle_markers: got %0d bad expected 0", marks); end
        n_vec++; if (rx_decode(f) !== 32'd0) begin n_err++; $display("FAIL idle_decode: got %h expected 0", rx_decode(f)); end
        @(negedge clk);
        n_vec++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL idle_period: got %b expected 1", frame_start); end
        sync_frame(ok);
        grab_frame(f, gap, marks);
        n_vec++; if (f !== F_IDLE) begin n_err++; $display("FAIL idle_frame2: got %h expected %h", f, F_IDLE); end
    endtask

    task automatic test_single_word;
        logic [47:0] f;
        logic        gap;
        int          marks;
        bit          ok;
        sync_frame(ok);
        repeat (5) @(negedge clk);
        send_word(32'h12345678);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL single_in_ready: got %b expected 0", in_ready); end
        sync_frame(ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL single_sync: got %b expected 1", ok); end
        grab_frame(f, gap, marks);
        n_vec++; if (f !== F_1234) begin n_err++; $display("FAIL single_frame: got %h expected %h", f, F_1234); end
        n_vec++; if (rx_decode(f) !== 32'h12345678) begin n_err++; $display("FAIL single_decode: got %h expected 12345678", rx_decode(f)); end
        n_vec++; if (marks !== 0 || gap !== 1'b0) begin n_err++; $display("FAIL single_markers: got %0d/%b expected 0/0", marks, gap); end
        sync_frame(ok);
        grab_frame(f, gap, marks);
        n_vec++; if (f !== F_1234) begin n_err++; $display("FAIL single_repeat: got %h expected %h", f, F_1234); end
    endtask

    task automatic test_wrap;
        logic [47:0] f;
        logic        gap;
        int          marks;
        bit          ok;
        sync_frame(ok);
        repeat (3) @(negedge clk);
        send_word(32'hFFFFFFFF);
        sync_frame(ok);
        grab_frame(f, gap, marks);
        n_vec++; if (f !== F_FFFF) begin n_err++; $display("FAIL wrap_frame: got %h expected %h", f, F_FFFF); end
        n_vec++; if (f[7:0] !== 8'hA5 || f[31:24] !== 8'h5A) begin n_err++; $display("FAIL wrap_marks: got %h/%h expected a5/5a", f[7:0], f[31:24]); end
        n_vec++; if (rx_decode(f) !== 32'hFFFFFFFF) begin n_err++; $display("FAIL wrap_decode: got %h expected ffffffff", rx_decode(f)); end
    endtask

    task automatic test_back_to_back;
        logic [47:0] f;
        logic        gap;
        int          marks;
        int          n;
        bit          ok;
        sync_frame(ok);
        code_in  = 32'hAAAA0001;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_drop: got %b expected 0", in_ready); end
        code_in = 32'h0000BBBB;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_vec++; if (in_ready !== 1'b1 || frame_done !== 1'b1) begin n_err++; $display("FAIL b2b_ready_rise: got ready=%b done=%b expected 1/1", in_ready, frame_done); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++; if (frame_start !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_second_accept: got start=%b ready=%b expected 1/0", frame_start, in_ready); end
        grab_frame(f, gap, marks);
        n_vec++; if (f !== F_AAAA) begin n_err++; $display("FAIL b2b_first: got %h expected %h", f, F_AAAA); end
        sync_frame(ok);
        grab_frame(f, gap, marks);
        n_vec++; if (f !== F_BBBB) begin n_err++; $display("FAIL b2b_second: got %h expected %h", f, F_BBBB); end
        sync_frame(ok);
        grab_frame(f, gap, marks);
        n_vec++; if (rx_decode(f) !== 32'h0000BBBB) begin n_err++; $display("FAIL b2b_repeat: got %h expected 0000bbbb", rx_decode(f)); end
    endtask

    task automatic test_slot48;
        logic [47:0] f;
        logic        gap;
        int          marks;
        bit          ok;
        sync_frame(ok);
        repeat (47) @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL s48_ready: got %b expected 1", in_ready); end
        send_word(32'hCAFE0102);
        n_vec++; if (in_ready !== 1'b0 || frame_done !== 1'b1) begin n_err++; $display("FAIL s48_captured: got ready=%b done=%b expected 0/1", in_ready, frame_done); end
        sync_frame(ok);
        grab_frame(f, gap, marks);
        n_vec++; if (f !== F_BBBB) begin n_err++; $display("FAIL s48_old_word: got %h expected %h", f, F_BBBB); end
        sync_frame(ok);
        grab_frame(f, gap, marks);
        n_vec++; if (f !== F_CAFE) begin n_err++; $display("FAIL s48_new_word: got %h expected %h", f, F_CAFE); end
    endtask

    task automatic test_mid_reset;
        logic [47:0] f;
        logic        gap;
        int          marks;
        bit          ok;
        sync_frame(ok);
        repeat (3) @(negedge clk);
        send_word(32'h0BADF00D);
        repeat (16) @(negedge clk);
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mrst_hold_full: got %b expected 0", in_ready); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++; if (code !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL mrst_state: got code=%b ready=%b expected 0/1", code, in_ready); end
        n_vec++; if (frame_start !== 1'b0 || frame_done !== 1'b0) begin n_err++; $display("FAIL mrst_pulses: got %b/%b expected 0/0", frame_start, frame_done); end
        rst = 1'b0;
        @(negedge clk);
        grab_frame(f, gap, marks);
        n_vec++; if (f !== F_IDLE || marks !== 0) begin n_err++; $display("FAIL mrst_restart: got %h/%0d expected %h/0", f, marks, F_IDLE); end
        sync_frame(ok);
        grab_frame(f, gap, marks);
        n_vec++; if (f !== F_IDLE) begin n_err++; $display("FAIL mrst_discard: got %h expected %h", f, F_IDLE); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        code_in  = '0;
        @(negedge clk);
        test_reset();
        test_idle();
        test_single_word();
        test_wrap();
        test_back_to_back();
        test_slot48();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
